reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-back end of the register-file interface: MEM/WB pipeline register, write-data select (memory vs ALU), 32x64 register file and two combinational read ports with write-through bypass.
- Decode reads operands through the read ports. Memory stage results enter on the input side.
- Also keeps a 32-bit retired-instruction counter for bench and perf checks.

Parameters:
- WORD, 64, datapath width in bits.
- NREGS, 32, number of architectural registers.
- ADDR_W, 5, register index width.
- XZR_IDX, 31, index of the hardwired zero register.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_valid  in  1  memory stage presents a valid instruction this cycle.
- mem_reg_write  in  1  the instruction writes a register.
- mem_to_reg  in  1  1 selects read_data, 0 selects alu_result.
- mem_rd  in  ADDR_W  destination register index.
- alu_result  in  WORD  ALU result from execute/memory.
- read_data  in  WORD  data-memory load result.
- stall  in  1  hold the MEM/WB register; suppress commit.
- flush  in  1  replace the next MEM/WB load with a bubble.
- rs1_addr  in  ADDR_W  read port 1 index.
- rs2_addr  in  ADDR_W  read port 2 index.
- read_data1  out  WORD  read port 1 data.
- read_data2  out  WORD  read port 2 data.
- write_data  out  WORD  selected write-back value of the held instruction.
- wb_valid  out  1  MEM/WB register holds a valid instruction.
- wb_we  out  1  a register-file write commits this cycle.
- wb_rd  out  ADDR_W  destination index held in MEM/WB.
- retire_count  out  CNT_W  count of committed valid instructions.

Behaviour:
- Reset (asynchronous, active-high):
  - MEM/WB fields cleared: valid=0, reg_write=0, mem_to_reg=0, rd=0, both data fields=0.
  - All NREGS registers set to 0 and retire_count set to 0.
  - As a result write_data=0, wb_valid=0, wb_we=0, wb_rd=0.
  - read_data1/2 return 0 for every index while reset is held and afterwards until a write lands.
- MEM/WB load on each rising edge:
  - If flush=1: load a bubble (valid=0, reg_write=0, others 0). flush wins over stall.
  - Else if stall=1: hold the current contents.
  - Else: capture the mem_* inputs, alu_result and read_data.
- write_data is combinational from the MEM/WB register: mem_to_reg ? read_data_q : alu_result_q.
- Commit condition: commit = wb_valid & ~stall. wb_we = commit & reg_write_q & (wb_rd != XZR_IDX).
- On a rising edge with wb_we=1: regfile[wb_rd] <= write_data.
- On a rising edge with commit=1: retire_count increments by 1 and wraps modulo 2^CNT_W (0xFFFFFFFF -> 0).
- A stalled instruction commits exactly once: in the first cycle stall is low.
- A valid instruction with reg_write=0 (store, branch) still retires but writes nothing.
- Writes to index XZR_IDX are discarded and the instruction still retires.
- Read ports are combinational, evaluated independently per port:
  - index == XZR_IDX: return 0, even if a write to 31 is pending.
  - else if wb_valid & reg_write_q & index == wb_rd: return write_data. The bypass applies even while stall=1.
  - else: return regfile[index].
- Latency:
  - The input captured at edge N is visible through bypass in cycle N..N+1.
  - It is in the register file from edge N+1, provided it is not stalled.
  - So decode sees the value in the same cycle the write-back stage holds it.
- Simultaneous events:
  - flush and commit in the same cycle: the held instruction still commits at that edge, then the bubble loads.
  - Both read ports may address the same register and get identical data.
- Reset mid-operation: the pending write is lost, regfile and counter are cleared, and no partial state survives.

Decomposition:
- Shared package (definitions header): WORD, NREGS, ADDR_W, XZR_IDX, CNT_W, and the MEM/WB field layout constants.
- One natural sub-module, regfile_2r1w: the storage array with two combinational read ports and one synchronous write port, including asynchronous clear and XZR masking.
- Bypass, the MEM/WB register and the counter live in the top module.

Test Plan:
- Reset then write: after reset, present valid, reg_write=1, mem_to_reg=0, rd=5, alu_result=0x1234. At the next edge read_data1 with rs1=5 gives 0x1234 via bypass, wb_we=1. After the following edge regfile[5]=0x1234 and retire_count=1.
- Load select: rd=7, mem_to_reg=1, read_data=0xDEADBEEF, alu_result=0x10 -> write_data=0xDEADBEEF and regfile[7]=0xDEADBEEF.
- XZR: write 0xFFFF to rd=31 -> read of index 31 returns 0, wb_we=0, retire_count still increments.
- Stall: load rd=3, value 0xAA, then hold stall=1 for 3 cycles -> wb_we=0 and the counter is unchanged while stalled; bypass on rs2=3 returns 0xAA throughout; exactly one commit after stall drops.
- Flush vs stall: assert flush and stall together with a valid input -> next cycle wb_valid=0, and the held instruction committed only if stall was low.
- Counter wrap and async reset: force retire_count to 0xFFFFFFFF, commit one instruction -> 0. Then assert reset mid-cycle -> all outputs and registers read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the write-back stage: datapath sizes, the MEM/WB
// register layout and the zero-register test.
package reg_writeback_pkg;

  localparam int WORD    = 64;
  localparam int NREGS   = 32;
  localparam int ADDR_W  = 5;
  localparam int XZR_IDX = 31;
  localparam int CNT_W   = 32;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [ADDR_W-1:0] rd;
    logic [WORD-1:0]   alu_result;
    logic [WORD-1:0]   read_data;
  } mem_wb_t;

  localparam int      MEM_WB_W      = $bits(mem_wb_t);
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  function automatic logic is_xzr(input logic [ADDR_W-1:0] idx);
    return idx == ADDR_W'(XZR_IDX);
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Memory-stage inputs, decode read ports and write-back status of the
// register-file back end, bundled as one interface.
interface reg_writeback_if #(
    parameter int CNT_W = reg_writeback_pkg::CNT_W
);
    import reg_writeback_pkg::*;

    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_to_reg;
    logic [ADDR_W-1:0] mem_rd;
    logic [WORD-1:0]   alu_result;
    logic [WORD-1:0]   read_data;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [WORD-1:0]   read_data1;
    logic [WORD-1:0]   read_data2;
    logic [WORD-1:0]   write_data;
    logic              wb_valid;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output mem_valid, mem_reg_write, mem_to_reg, mem_rd, alu_result, read_data,
        output stall, flush, rs1_addr, rs2_addr,
        input  read_data1, read_data2, write_data, wb_valid, wb_we, wb_rd, retire_count
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_to_reg, mem_rd, alu_result, read_data,
        input  stall, flush, rs1_addr, rs2_addr,
        output read_data1, read_data2, write_data, wb_valid, wb_we, wb_rd, retire_count
    );

endinterface

// File: rtl/reg_writeback_regfile_2r1w.sv
// 32x64 register storage: one synchronous write port, two combinational read
// ports, asynchronous clear, index XZR_IDX hardwired to zero.
module regfile_2r1w
    import reg_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WORD-1:0]   rdata1,
    output logic [WORD-1:0]   rdata2
);

    logic [WORD-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we && !is_xzr(waddr)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = is_xzr(raddr1) ? '0 : regs_q[raddr1];
    assign rdata2 = is_xzr(raddr2) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: MEM/WB register, write-data select, register file with
// write-through bypass on both read ports, and the retired-instruction counter.
module reg_writeback #(
    parameter int CNT_W = reg_writeback_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    reg_writeback_if.slave  bus
);
    import reg_writeback_pkg::*;

    mem_wb_t           wb_p1;
    logic [CNT_W-1:0]  retire_cnt_p1;
    logic [WORD-1:0]   wdata;
    logic              commit;
    logic              wb_we;
    logic [WORD-1:0]   rf_rdata1;
    logic [WORD-1:0]   rf_rdata2;

    // The held instruction is forwarded to decode as soon as it sits in
    // MEM/WB, including while stalled, so decode never waits for the write.
    function automatic logic [WORD-1:0] bypass_rd(
        input logic [ADDR_W-1:0] idx,
        input logic [WORD-1:0]   rf_q,
        input mem_wb_t           wb,
        input logic [WORD-1:0]   wb_data
    );
        if (is_xzr(idx))                                return '0;
        else if (wb.valid && wb.reg_write && idx == wb.rd) return wb_data;
        else                                            return rf_q;
    endfunction

    // ---- MEM -> WB boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_p1 <= MEM_WB_BUBBLE;
        end else if (bus.flush) begin
            wb_p1 <= MEM_WB_BUBBLE;
        end else if (!bus.stall) begin
            wb_p1 <= '{valid:      bus.mem_valid,
                       reg_write:  bus.mem_reg_write,
                       mem_to_reg: bus.mem_to_reg,
                       rd:         bus.mem_rd,
                       alu_result: bus.alu_result,
                       read_data:  bus.read_data};
        end
    end

    assign wdata  = wb_p1.mem_to_reg ? wb_p1.read_data : wb_p1.alu_result;
    assign commit = wb_p1.valid & ~bus.stall;
    assign wb_we  = commit & wb_p1.reg_write & ~is_xzr(wb_p1.rd);

    // ---- WB commit ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_p1 <= '0;
        end else if (commit) begin
            retire_cnt_p1 <= retire_cnt_p1 + CNT_W'(1);
        end
    end

    regfile_2r1w u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_p1.rd),
        .wdata  (wdata),
        .raddr1 (bus.rs1_addr),
        .raddr2 (bus.rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    assign bus.read_data1   = bypass_rd(bus.rs1_addr, rf_rdata1, wb_p1, wdata);
    assign bus.read_data2   = bypass_rd(bus.rs2_addr, rf_rdata2, wb_p1, wdata);
    assign bus.write_data   = wdata;
    assign bus.wb_valid     = wb_p1.valid;
    assign bus.wb_we        = wb_we;
    assign bus.wb_rd        = wb_p1.rd;
    assign bus.retire_count = retire_cnt_p1;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized
// traffic compared against a behavioural model of the write-back stage.
module tb_reg_writeback;

    logic clk;
    logic reset;

    reg_writeback_if #(.CNT_W(32)) bus ();
    reg_writeback_if #(.CNT_W(4))  bus_w ();

    reg_writeback #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow-counter copy exercising retire_count wrap-around.
    reg_writeback #(.CNT_W(4)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: architectural register file plus the one instruction held in write-back.
    logic [63:0] m_rf [32];
    bit          m_hv;
    bit          m_hwe;
    logic [4:0]  m_hrd;
    logic [63:0] m_hval;
    logic [31:0] m_cnt;
    bit          w_hv;
    logic [3:0]  w_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] idx);
        if (idx == 5'd31)                         return 64'd0;
        if (m_hv && m_hwe && idx == m_hrd)        return m_hval;
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        m_hv = 0; m_hwe = 0; m_hrd = 0; m_hval = 0; m_cnt = 0;
        w_hv = 0; w_cnt = 0;
    endtask

    task automatic check_all();
        bit exp_we;
        exp_we = m_hv && !bus.stall && m_hwe && (m_hrd != 5'd31);
        check("wb_valid",   64'(bus.wb_valid),     64'(m_hv));
        check("wb_we",      64'(bus.wb_we),        64'(exp_we));
        check("wb_rd",      64'(bus.wb_rd),        64'(m_hrd));
        check("write_data", bus.write_data,        m_hval);
        check("read_data1", bus.read_data1,        m_read(bus.rs1_addr));
        check("read_data2", bus.read_data2,        m_read(bus.rs2_addr));
        check("retire_cnt", 64'(bus.retire_count), 64'(m_cnt));
        check("wrap_cnt",   64'(bus_w.retire_count), 64'(w_cnt));
    endtask

    // One rising edge; model effects come from the inputs stable before it.
    task automatic tick();
        bit c;
        bit wc;
        c  = m_hv && !bus.stall;
        wc = w_hv;
        @(posedge clk);
        if (c) begin
            m_cnt = m_cnt + 1;
            if (m_hwe && m_hrd != 5'd31) m_rf[m_hrd] = m_hval;
        end
        if (bus.flush) begin
            m_hv = 0; m_hwe = 0; m_hrd = 0; m_hval = 0;
        end else if (!bus.stall) begin
            m_hv   = bus.mem_valid;
            m_hwe  = bus.mem_reg_write;
            m_hrd  = bus.mem_rd;
            m_hval = bus.mem_to_reg ? bus.read_data : bus.alu_result;
        end
        if (wc) w_cnt = w_cnt + 4'd1;
        w_hv = 1;
        #1;
    endtask

    task automatic drive(input bit v, input bit rw, input bit m2r, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] rdat);
        bus.mem_valid     = v;
        bus.mem_reg_write = rw;
        bus.mem_to_reg    = m2r;
        bus.mem_rd        = rd;
        bus.alu_result    = alu;
        bus.read_data     = rdat;
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    // Reset is raised and checked between clock edges to show it acts immediately.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(31 - i);
            #1;
            check("rst_rd1", bus.read_data1, 64'd0);
            check("rst_rd2", bus.read_data2, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.stall = 0; bus.flush = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
        bus_w.mem_valid = 1; bus_w.mem_reg_write = 1; bus_w.mem_to_reg = 0;
        bus_w.mem_rd = 5'd1; bus_w.alu_result = 64'h5; bus_w.read_data = 64'h0;
        bus_w.stall = 0; bus_w.flush = 0; bus_w.rs1_addr = 0; bus_w.rs2_addr = 0;

        do_reset();

        // Reset then write, bypass visible while held
        drive(1, 1, 0, 5'd5, 64'h1234, 64'h0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 0); bus.rs1_addr = 5'd5;
        settle();
        check("t1_bypass", bus.read_data1, 64'h1234);
        check("t1_we", 64'(bus.wb_we), 64'd1);
        tick();
        settle();
        check("t1_rf5", bus.read_data1, 64'h1234);
        check("t1_cnt", 64'(bus.retire_count), 64'd1);

        // Load selects memory data
        drive(1, 1, 1, 5'd7, 64'h10, 64'hDEADBEEF);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        check("t2_wdata", bus.write_data, 64'hDEADBEEF);
        tick();
        bus.rs1_addr = 5'd7;
        settle();
        check("t2_rf7", bus.read_data1, 64'hDEADBEEF);

        // Write to the zero register
        drive(1, 1, 0, 5'd31, 64'hFFFF, 64'h0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 0); bus.rs1_addr = 5'd31;
        settle();
        check("t3_rd31", bus.read_data1, 64'd0);
        check("t3_we", 64'(bus.wb_we), 64'd0);
        tick();
        settle();
        check("t3_cnt", 64'(bus.retire_count), 64'd3);

        // Stall holds the instruction; one commit after release
        drive(1, 1, 0, 5'd3, 64'hAA, 64'h0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 0); bus.stall = 1; bus.rs2_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t4_st_we", 64'(bus.wb_we), 64'd0);
            check("t4_st_byp", bus.read_data2, 64'hAA);
            check("t4_st_cnt", 64'(bus.retire_count), 64'd3);
            tick();
        end
        bus.stall = 0;
        settle();
        check("t4_rel_we", 64'(bus.wb_we), 64'd1);
        tick();
        settle();
        check("t4_cnt", 64'(bus.retire_count), 64'd4);
        check("t4_we_after", 64'(bus.wb_we), 64'd0);

        // Flush together with stall: bubble loads, held instruction lost
        drive(1, 1, 0, 5'd9, 64'h55, 64'h0);
        settle(); tick();
        drive(1, 1, 0, 5'd10, 64'h77, 64'h0); bus.flush = 1; bus.stall = 1;
        settle();
        check("t5_we", 64'(bus.wb_we), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0); bus.flush = 0; bus.stall = 0; bus.rs1_addr = 5'd9;
        settle();
        check("t5_valid", 64'(bus.wb_valid), 64'd0);
        check("t5_cnt", 64'(bus.retire_count), 64'd4);
        check("t5_rf9", bus.read_data1, 64'd0);

        // Flush without stall: held instruction commits, then bubble
        drive(1, 1, 0, 5'd11, 64'h66, 64'h0);
        settle(); tick();
        drive(1, 1, 0, 5'd12, 64'h88, 64'h0); bus.flush = 1;
        settle();
        check("t6_we", 64'(bus.wb_we), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0); bus.flush = 0; bus.rs1_addr = 5'd11;
        settle();
        check("t6_valid", 64'(bus.wb_valid), 64'd0);
        check("t6_cnt", 64'(bus.retire_count), 64'd5);
        check("t6_rf11", bus.read_data1, 64'h66);
        tick();

        // Randomized traffic with a reset dropped in mid-run
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) begin
                #2;
                do_reset();
            end
            drive(($urandom_range(3) != 0), ($urandom_range(3) != 0), 1'($urandom),
                  ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom});
            bus.stall    = ($urandom_range(3) == 0);
            bus.flush    = ($urandom_range(7) == 0);
            bus.rs1_addr = $urandom_range(1) ? m_hrd : 5'($urandom);
            bus.rs2_addr = $urandom_range(1) ? m_hrd : 5'($urandom);
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
